pipememctl: RTL

PIPEMEMCTL -- requirements
Module: pipememctl

---
 rtl/pipememctl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipememctl.sv
`timescale 1ns/1ps
// pipememctl: MEM stage of a 5-stage pipeline. Holds the EX/MEM and MEM/WB
// pipeline registers and runs a level-held data-memory handshake. A small
// IDLE/BUSY FSM with a wait counter times out accesses that are never acked.
// It also flags misaligned word accesses and freezes upstream stages while an
// access is outstanding.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ealu, eb, ern                execute-stage result/address, store data, dest reg
//   ewreg, em2reg, ewmem, evalid execute-stage control flags
//   dmem_req, dmem_we            data-memory request (level) and write enable
//   dmem_addr, dmem_wdata        EX/MEM address and store data
//   dmem_rdata, dmem_ack         read data and one-cycle completion pulse
//   mem_stall                    combinational freeze request to upstream
//   wmo, walu, wrn, wwreg, wm2reg MEM/WB register contents
//   mem_err                      sticky errors: [0] timeout, [1] misaligned
module pipememctl (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic        evalid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [1:0]  mem_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 4;
  localparam int unsigned EW   = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] b;
    logic [RW-1:0]   rn;
    logic            wreg;
    logic            m2reg;
    logic            wmem;
    logic            valid;
  } exmem_t;

  typedef struct packed {
    logic [XLEN-1:0] mo;
    logic [XLEN-1:0] alu;
    logic [RW-1:0]   rn;
    logic            wreg;
    logic            m2reg;
  } memwb_t;

  typedef enum logic {IDLE, BUSY} state_e;

  exmem_t        exmem_q, exmem_d;
  memwb_t        memwb_q, memwb_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] err_q, err_d;

  logic is_mem;
  logic misaligned;
  logic memop;
  logic timeout;
  logic complete;
  logic stall;

  // Access classification and handshake completion
  always_comb begin
    is_mem     = exmem_q.valid & (exmem_q.m2reg | exmem_q.wmem);
    misaligned = is_mem & (exmem_q.alu[1:0] != 2'b00);
    memop      = is_mem & ~misaligned;
    timeout    = (state_q == BUSY) & ~dmem_ack & (cnt_q == CNT_MAX);
    complete   = memop & (dmem_ack | timeout);
    stall      = memop & ~complete;
  end

  // Memory-side outputs; reset masks request and stall immediately
  always_comb begin
    dmem_req   = memop & ~reset;
    dmem_we    = memop & ~reset & exmem_q.wmem;
    mem_stall  = stall & ~reset;
    dmem_addr  = exmem_q.alu;
    dmem_wdata = exmem_q.b;
  end

  // Next-state: FSM, wait counter, sticky errors and pipeline registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    exmem_d = exmem_q;
    memwb_d = '0;

    case (state_q)
      IDLE: begin
        if (memop && !dmem_ack) begin
          state_d = BUSY;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        // !memop cannot occur while EX/MEM is frozen; recover to IDLE anyway
        if (!memop || complete) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    err_d = err_q | {misaligned, memop & timeout};

    if (!stall) begin
      exmem_d = '{alu: ealu, b: eb, rn: ern, wreg: ewreg, m2reg: em2reg,
                  wmem: ewmem, valid: evalid};
      memwb_d.alu   = exmem_q.alu;
      memwb_d.rn    = exmem_q.rn;
      memwb_d.wreg  = exmem_q.wreg  & exmem_q.valid & ~misaligned;
      memwb_d.m2reg = exmem_q.m2reg & exmem_q.valid & ~misaligned;
      // Timed-out or non-load completions return zero
      if (memop && exmem_q.m2reg && dmem_ack) begin
        memwb_d.mo = dmem_rdata;
      end
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign wmo     = memwb_q.mo;
  assign walu    = memwb_q.alu;
  assign wrn     = memwb_q.rn;
  assign wwreg   = memwb_q.wreg;
  assign wm2reg  = memwb_q.m2reg;
  assign mem_err = err_q;

endmodule
